// File: rtl/cache_fill_fsm.sv
// Cache line fill controller: on a miss, issues 8 pipelined word reads and writes returned words into the data array, then the tag.
// Optional FILL_MISS_COUNT_EN macro enables a saturating completed-fill counter on miss_count.
module cache_fill_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic [15:0] memory_data,
  input  logic        memory_data_valid,
  output logic        fsm_busy,
  output logic        mem_en,
  output logic [15:0] memory_address,
  output logic [15:0] fill_address,
  output logic [15:0] fill_data,
  output logic        write_data_array,
  output logic        write_tag_array,
  output logic [15:0] miss_count
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_q, state_d;
  logic [11:0] base_q, base_d;
  logic [2:0]  issue_cnt_q, issue_cnt_d;
  logic        issue_done_q, issue_done_d;
  logic [2:0]  rcv_cnt_q, rcv_cnt_d;

  logic unused_offset_bits;
  assign unused_offset_bits = ^miss_address[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      base_q       <= '0;
      issue_cnt_q  <= '0;
      issue_done_q <= 1'b0;
      rcv_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      issue_cnt_q  <= issue_cnt_d;
      issue_done_q <= issue_done_d;
      rcv_cnt_q    <= rcv_cnt_d;
    end
  end

  // issue_done_q marks the 8th request, since the 3-bit issue counter wraps back to 0
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    issue_cnt_d  = issue_cnt_q;
    issue_done_d = issue_done_q;
    rcv_cnt_d    = rcv_cnt_q;
    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          state_d      = WAIT;
          base_d       = miss_address[15:4];
          issue_cnt_d  = '0;
          issue_done_d = 1'b0;
          rcv_cnt_d    = '0;
        end
      end
      WAIT: begin
        if (!issue_done_q) begin
          issue_cnt_d = issue_cnt_q + 3'd1;
          if (issue_cnt_q == 3'd7) issue_done_d = 1'b1;
        end
        if (memory_data_valid) begin
          rcv_cnt_d = rcv_cnt_q + 3'd1;
          if (rcv_cnt_q == 3'd7) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are suppressed while rst is high so a fill cut short by reset writes nothing
  always_comb begin
    fsm_busy         = 1'b0;
    mem_en           = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    memory_address   = {base_q, issue_cnt_q, 1'b0};
    fill_address     = {base_q, rcv_cnt_q, 1'b0};
    fill_data        = memory_data;
    case (state_q)
      IDLE: fsm_busy = miss_detected;
      WAIT: begin
        if (!rst) begin
          fsm_busy         = 1'b1;
          mem_en           = !issue_done_q;
          write_data_array = memory_data_valid;
          write_tag_array  = memory_data_valid && (rcv_cnt_q == 3'd7);
        end
      end
      default: fsm_busy = 1'b0;
    endcase
  end

`ifdef FILL_MISS_COUNT_EN
  logic [15:0] miss_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_count_q <= '0;
    end else if (write_tag_array && (miss_count_q != 16'hFFFF)) begin
      miss_count_q <= miss_count_q + 16'd1;
    end
  end

  assign miss_count = miss_count_q;
`else
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: expected request addresses and array writes are queued as stimulus is driven.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        mem_en;
  logic [15:0] memory_address;
  logic [15:0] fill_address;
  logic [15:0] fill_data;
  logic        write_data_array;
  logic        write_tag_array;
  logic [15:0] miss_count;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        tag;
  } wr_t;

  logic [15:0] req_q[$];
  wr_t         wr_q[$];
  int tests_run = 0;
  int tests_failed = 0;
  int fills = 0;

  cache_fill_fsm dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data(memory_data), .memory_data_valid(memory_data_valid), .fsm_busy(fsm_busy),
    .mem_en(mem_en), .memory_address(memory_address), .fill_address(fill_address),
    .fill_data(fill_data), .write_data_array(write_data_array),
    .write_tag_array(write_tag_array), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] exp_miss_count();
`ifdef FILL_MISS_COUNT_EN
    return 16'(fills);
`else
    return 16'h0000;
`endif
  endfunction

  // Cycle 0 raises the miss; requests are expected on cycles 1..8; valid pulses at first, first+period, ...
  task automatic run_fill(input logic [15:0] addr, input int first, input int period,
                          input bit hold, input logic [15:0] hold_addr, input int stop_after);
    int n = 0;
    bit v;
    bit finished = 0;
    logic [11:0] base;
    wr_t e;
    logic [15:0] ra;
    base = addr[15:4];
    for (int c = 0; c < 80 && !finished; c++) begin
      miss_detected = (c == 0) || hold;
      miss_address  = (c == 0) ? addr : hold_addr;
      if (c == 0)
        for (int k = 0; k < 8; k++) req_q.push_back({base, 3'(k), 1'b0});
      v = (c >= first) && (((c - first) % period) == 0) && (n < stop_after);
      memory_data_valid = v;
      memory_data = v ? 16'(32'hA000 + n) : 16'($urandom);
      if (v) wr_q.push_back('{addr: {base, 3'(n), 1'b0}, data: 16'(32'hA000 + n), tag: (n == 7)});
      #1;
      tests_run++;
      if (fsm_busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL fill_busy: cycle %0d fsm_busy=%b expected 1", c, fsm_busy);
      end
      tests_run++;
      if (mem_en !== ((c >= 1) && (c <= 8))) begin
        tests_failed++;
        $display("FAIL fill_mem_en: cycle %0d mem_en=%b expected %b", c, mem_en, (c >= 1) && (c <= 8));
      end
      if (mem_en === 1'b1 && req_q.size() > 0) begin
        ra = req_q.pop_front();
        tests_run++;
        if (memory_address !== ra) begin
          tests_failed++;
          $display("FAIL req_addr: cycle %0d memory_address=%h expected %h", c, memory_address, ra);
        end
      end
      tests_run++;
      if (write_data_array !== v) begin
        tests_failed++;
        $display("FAIL wr_en: cycle %0d write_data_array=%b expected %b", c, write_data_array, v);
      end
      if (v) begin
        e = wr_q.pop_front();
        tests_run++;
        if (fill_address !== e.addr || fill_data !== e.data || write_tag_array !== e.tag) begin
          tests_failed++;
          $display("FAIL wr_word: cycle %0d addr=%h data=%h tag=%b expected addr=%h data=%h tag=%b",
                   c, fill_address, fill_data, write_tag_array, e.addr, e.data, e.tag);
        end
      end else begin
        tests_run++;
        if (write_tag_array !== 1'b0) begin
          tests_failed++;
          $display("FAIL tag_idle: cycle %0d write_tag_array=%b expected 0", c, write_tag_array);
        end
      end
      @(posedge clk); #1;
      if (v) begin
        n++;
        if (n == 8) begin
          fills++;
          tests_run++;
          if (req_q.size() != 0) begin
            tests_failed++;
            $display("FAIL req_count: %0d requests missing, expected 0", req_q.size());
          end
          tests_run++;
          if (miss_count !== exp_miss_count()) begin
            tests_failed++;
            $display("FAIL miss_count_fill: miss_count=%h expected %h", miss_count, exp_miss_count());
          end
        end
        if (n == stop_after) finished = 1;
      end
    end
    if (!finished) begin
      tests_run++;
      tests_failed++;
      $display("FAIL fill_timeout: only %0d of %0d words returned", n, stop_after);
    end
  endtask

  task automatic test_idle(input bit stray);
    miss_detected = 1'b0;
    miss_address = 16'($urandom);
    memory_data_valid = stray;
    memory_data = 16'($urandom);
    #1;
    tests_run++;
    if (fsm_busy !== 1'b0 || mem_en !== 1'b0 || write_data_array !== 1'b0 || write_tag_array !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle: busy=%b mem_en=%b wda=%b wta=%b expected 0000",
               fsm_busy, mem_en, write_data_array, write_tag_array);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    miss_detected = 1'b0;
    miss_address = '0;
    memory_data = '0;
    memory_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (fsm_busy !== 1'b0 || mem_en !== 1'b0 || write_data_array !== 1'b0 ||
        write_tag_array !== 1'b0 || miss_count !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b mem_en=%b wda=%b wta=%b mc=%h expected 0000 0000",
               fsm_busy, mem_en, write_data_array, write_tag_array, miss_count);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    test_idle(1'b0);
  endtask

  task automatic test_single_fill();
    run_fill(16'h1234, 5, 1, 1'b0, 16'h0000, 8);
    test_idle(1'b1);
  endtask

  task automatic test_gapped();
    run_fill(16'h4A7C, 5, 3, 1'b0, 16'h0000, 8);
    test_idle(1'b0);
  endtask

  task automatic test_back_to_back();
    run_fill(16'h1234, 5, 1, 1'b1, 16'h5678, 8);
    run_fill(16'h5678, 5, 1, 1'b0, 16'h0000, 8);
    test_idle(1'b0);
  endtask

  task automatic test_reset_mid_fill();
    run_fill(16'h2468, 5, 1, 1'b0, 16'h0000, 3);
    rst = 1'b1;
    miss_detected = 1'b0;
    memory_data_valid = 1'b1;
    #1;
    tests_run++;
    if (fsm_busy !== 1'b0 || mem_en !== 1'b0 || write_data_array !== 1'b0 || write_tag_array !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_fill: busy=%b mem_en=%b wda=%b wta=%b expected 0000",
               fsm_busy, mem_en, write_data_array, write_tag_array);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req_q.delete();
    wr_q.delete();
    fills = 0;
    tests_run++;
    if (miss_count !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_miss_count: miss_count=%h expected 0000", miss_count);
    end
    repeat (5) test_idle(1'b1);
  endtask

  task automatic test_miss_count();
    logic [15:0] want;
    run_fill(16'h0F00, 5, 1, 1'b0, 16'h0000, 8);
    test_idle(1'b0);
    run_fill(16'hFFF0, 6, 2, 1'b0, 16'h0000, 8);
    test_idle(1'b0);
    run_fill(16'h8001, 5, 1, 1'b0, 16'h0000, 8);
    test_idle(1'b1);
`ifdef FILL_MISS_COUNT_EN
    want = 16'd3;
`else
    want = 16'd0;
`endif
    tests_run++;
    if (miss_count !== want) begin
      tests_failed++;
      $display("FAIL miss_count_final: miss_count=%h expected %h", miss_count, want);
    end
  endtask

  initial begin
    test_reset();
    test_single_fill();
    test_gapped();
    test_back_to_back();
    test_reset_mid_fill();
    test_miss_count();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
